// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: loader FSM states, block geometry and padding helpers.
// The compression engine imports this package as well.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PAD,
        PRESENT
    } loader_state_t;

    localparam int unsigned SHA_WORDS_PER_BLOCK = 16;
    localparam int unsigned SHA_BLOCK_BITS      = 512;
    localparam logic [31:0] SHA_PAD_WORD        = 32'h8000_0000;

    function automatic int unsigned sha_num_blocks(input int unsigned n);
        return (n + 2) / SHA_WORDS_PER_BLOCK + 1;
    endfunction

    // Message words that block b takes from memory: clamp(n - 16*b, 0, 16).
    function automatic logic [4:0] sha_words_in_block(input int unsigned n, input int unsigned b);
        int unsigned first;
        first = b * SHA_WORDS_PER_BLOCK;
        if (first >= n) return 5'd0;
        if (n - first >= SHA_WORDS_PER_BLOCK) return 5'd16;
        return 5'(n - first);
    endfunction

endpackage

// File: rtl/sha256_block_loader.sv
// Reads an N-word message from word-addressed memory, applies SHA-256 padding and
// hands out 512-bit blocks one at a time over a valid/ready handshake.
module sha256_block_loader
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               input_addr,
    output logic                      memory_clk,
    output logic [15:0]               memory_addr,
    input  logic [31:0]               memory_read_data,
    output logic [SHA_BLOCK_BITS-1:0] block_data,
    output logic                      block_valid,
    input  logic                      block_ready,
    output logic                      block_last,
    output logic [7:0]                block_index,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned NUM_BLOCKS  = sha_num_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_INDEX  = 8'(NUM_BLOCKS - 1);
    localparam logic [11:0] POS_N       = 12'(NUM_OF_WORDS);
    localparam logic [31:0] LENGTH_WORD = 32'(NUM_OF_WORDS * 32);

    loader_state_t state, state_next;

    logic [31:0] buf_q [16];
    logic [15:0] base_q;
    logic [7:0]  blk_q;
    logic [4:0]  j_q;
    logic [4:0]  k_cur;
    logic [4:0]  k_next;
    logic        is_last;
    logic [15:0] fetch_addr;

    assign memory_clk  = clk;
    assign k_cur       = sha_words_in_block(NUM_OF_WORDS, 32'(blk_q));
    assign k_next      = sha_words_in_block(NUM_OF_WORDS, 32'(blk_q) + 32'd1);
    assign is_last     = (blk_q == LAST_INDEX);
    assign fetch_addr  = base_q + {4'b0, blk_q, 4'b0} + 16'(j_q);
    assign block_index = blk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (j_q == k_cur) state_next = PAD;
            PAD:     state_next = PRESENT;
            PRESENT: begin
                if (block_ready) begin
                    if (is_last)              state_next = IDLE;
                    else if (k_next == 5'd0)  state_next = PAD;
                    else                      state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        block_valid = (state == PRESENT);
        block_last  = (state == PRESENT) && is_last;
        busy        = (state != IDLE);
    end

    always_comb begin
        block_data = '0;
        for (int unsigned w = 0; w < SHA_WORDS_PER_BLOCK; w++) begin
            block_data[SHA_BLOCK_BITS - 1 - 32 * w -: 32] = buf_q[4'(w)];
        end
    end

    // j_q counts issued addresses; the word for address j-1 is captured while j is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memory_addr <= '0;
            base_q      <= '0;
            blk_q       <= '0;
            j_q         <= '0;
            done        <= 1'b0;
            for (int unsigned w = 0; w < SHA_WORDS_PER_BLOCK; w++) begin
                buf_q[4'(w)] <= '0;
            end
        end else begin
            done <= (state == PRESENT) && block_ready && is_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q      <= input_addr;
                        memory_addr <= input_addr;
                        blk_q       <= '0;
                        j_q         <= '0;
                    end
                end
                FETCH: begin
                    if (j_q < k_cur) memory_addr <= fetch_addr;
                    if (j_q != 5'd0) buf_q[4'(j_q - 5'd1)] <= memory_read_data;
                    j_q <= j_q + 5'd1;
                end
                PAD: begin
                    // {blk_q, w} is the global word position within the padded message.
                    for (int unsigned w = 0; w < SHA_WORDS_PER_BLOCK; w++) begin
                        if ({blk_q, 4'(w)} == POS_N) begin
                            buf_q[4'(w)] <= SHA_PAD_WORD;
                        end else if ({blk_q, 4'(w)} > POS_N) begin
                            buf_q[4'(w)] <= (is_last && w == 15) ? LENGTH_WORD : '0;
                        end
                    end
                end
                PRESENT: begin
                    if (block_ready && !is_last) begin
                        blk_q <= blk_q + 8'd1;
                        j_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
